// File: rtl/corelet_ws_ctrl.sv
// Weight-stationary sequencer: walks every kernel position through load, flush, stream and drain.
// Optional macro CTRL_SFP_ACC_EN: accumulate psums in the SFP and reuse the same nij pmem words.
module corelet_ws_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int nij     = 36,
    parameter int kij     = 9,
    parameter int addr_bw = 11,
    parameter int w_base  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ofifo_valid,
    output logic [34:0]        inst,
    output logic               xmem_cen,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               pmem_cen,
    output logic               pmem_wen,
    output logic [addr_bw-1:0] pmem_addr,
    output logic               busy,
    output logic               done
);
    localparam int KW    = (kij > 1) ? $clog2(kij) : 1;
    localparam int I_MAX = (row + col > nij) ? row + col : nij;
    localparam int IW    = $clog2(I_MAX + 1);

    localparam logic [KW-1:0] K_LAST     = KW'(kij - 1);
    localparam logic [IW-1:0] COL_LAST   = IW'(col - 1);
    localparam logic [IW-1:0] FLUSH_LAST = IW'(row + col - 1);
    localparam logic [IW-1:0] NIJ_LAST   = IW'(nij - 1);
    localparam logic [IW-1:0] NIJ_CNT    = IW'(nij);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_LOAD  = 3'd1;
    localparam logic [2:0] S_W_KERN  = 3'd2;
    localparam logic [2:0] S_W_FLUSH = 3'd3;
    localparam logic [2:0] S_A_LOAD  = 3'd4;
    localparam logic [2:0] S_A_EXEC  = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]         state, nstate;
    logic [KW-1:0]      k, nk;
    logic [IW-1:0]      i, ni, widx;
    logic               wr;
    logic [34:0]        inst_n;
    logic               xcen_n, pcen_n, busy_n, done_n;
    logic [addr_bw-1:0] xaddr_n, paddr_n;

    // state/counters describe the cycle the registered outputs are presenting;
    // in DRAIN, i counts pmem writes already issued for this kernel position
    always_comb begin
        nstate = state;
        nk     = k;
        ni     = i + 1'b1;
        wr     = 1'b0;
        case (state)
            S_IDLE: begin
                nk = '0;
                ni = '0;
                if (start) nstate = S_W_LOAD;
            end
            S_W_LOAD:  if (i == COL_LAST)   begin nstate = S_W_KERN;  ni = '0; end
            S_W_KERN:  if (i == COL_LAST)   begin nstate = S_W_FLUSH; ni = '0; end
            S_W_FLUSH: if (i == FLUSH_LAST) begin nstate = S_A_LOAD;  ni = '0; end
            S_A_LOAD:  if (i == NIJ_LAST)   begin nstate = S_A_EXEC;  ni = '0; end
            S_A_EXEC: begin
                if (i == NIJ_LAST) begin
                    nstate = S_DRAIN;
                    wr     = ofifo_valid;
                    ni     = IW'(ofifo_valid);
                end
            end
            S_DRAIN: begin
                if (i == NIJ_CNT) begin
                    ni = '0;
                    if (k == K_LAST) begin
                        nstate = S_DONE;
                    end else begin
                        nstate = S_W_LOAD;
                        nk     = k + 1'b1;
                    end
                end else begin
                    wr = ofifo_valid;
                    ni = i + IW'(ofifo_valid);
                end
            end
            default: begin
                nstate = S_IDLE;
                nk     = '0;
                ni     = '0;
            end
        endcase
    end

    assign widx = (state == S_DRAIN) ? i : '0;

    always_comb begin
        inst_n  = '0;
        xcen_n  = 1'b1;
        xaddr_n = '0;
        pcen_n  = 1'b1;
        paddr_n = '0;
        case (nstate)
            S_W_LOAD: begin
                xcen_n  = 1'b0;
                xaddr_n = addr_bw'(w_base + int'(nk) * col + int'(ni));
            end
            S_W_KERN: begin
                inst_n[3] = 1'b1;
                inst_n[0] = 1'b1;
            end
            S_A_LOAD: begin
                xcen_n  = 1'b0;
                xaddr_n = addr_bw'(ni);
            end
            S_A_EXEC: begin
                inst_n[3] = 1'b1;
                inst_n[1] = 1'b1;
            end
            S_DRAIN: begin
                inst_n[6] = wr;
                pcen_n    = ~wr;
`ifdef CTRL_SFP_ACC_EN
                inst_n[33] = wr && (k != '0);
                paddr_n    = addr_bw'(widx);
`else
                paddr_n    = addr_bw'(int'(k) * nij + int'(widx));
`endif
            end
            default: ;
        endcase
        // xmem data arrives one cycle after the read, so the L0 write trails it
        inst_n[2] = ~xmem_cen;
        busy_n    = (nstate != S_IDLE) && (nstate != S_DONE);
        done_n    = (nstate == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            i         <= '0;
            inst      <= '0;
            xmem_cen  <= 1'b1;
            xmem_addr <= '0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nstate;
            k         <= nk;
            i         <= ni;
            inst      <= inst_n;
            xmem_cen  <= xcen_n;
            xmem_addr <= xaddr_n;
            pmem_cen  <= pcen_n;
            pmem_wen  <= pcen_n;
            pmem_addr <= paddr_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_corelet_ws_ctrl.sv
// Bench for corelet_ws_ctrl: vector table, hand-written corner sequences and randomized full runs.
// Follows CTRL_SFP_ACC_EN the same way the design build does.
module tb_corelet_ws_ctrl;
    localparam int ROW = 8, COL = 8, NIJ = 36, KIJ = 9, WB = 1024;

    logic        clk, reset, start, ofifo_valid;
    logic [34:0] inst;
    logic        xmem_cen, pmem_cen, pmem_wen, busy, done;
    logic [10:0] xmem_addr, pmem_addr;

    int n_cmp = 0;
    int n_err = 0;

    corelet_ws_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
        .inst(inst), .xmem_cen(xmem_cen), .xmem_addr(xmem_addr),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, ofv;
        logic [34:0] inst;
        logic        xcen;
        logic [10:0] xaddr;
        logic        pcen;
        logic [10:0] paddr;
        logic        busy, done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic st, input logic [34:0] in_w,
                                input logic xcen, input int xaddr, input logic bsy);
        vec_t v;
        v.rst = rst; v.st = st; v.ofv = 1'b1;
        v.inst = in_w; v.xcen = xcen; v.xaddr = 11'(xaddr);
        v.pcen = 1'b1; v.paddr = '0; v.busy = bsy; v.done = 1'b0;
        return v;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inst"}, inst, 0);
        chk({tag, "_xcen"}, xmem_cen, 1);
        chk({tag, "_xaddr"}, xmem_addr, 0);
        chk({tag, "_pcen_wen"}, {pmem_cen, pmem_wen}, 2'b11);
        chk({tag, "_paddr"}, pmem_addr, 0);
        chk({tag, "_busy_done"}, {busy, done}, 2'b00);
    endtask

    // Expected event streams built straight from the run description, independent of FSM shape.
    task automatic run_full(input bit rnd);
        int  exp_rd[$];
        int  exp_wa[$];
        bit  exp_acc[$];
        int  busy_cyc, nrd, nwr;
        bit  prev_ofv, prev_xcen, finished;
        string tag;
        tag = rnd ? "rnd" : "full";
        for (int kk = 0; kk < KIJ; kk++) begin
            for (int j = 0; j < COL; j++) exp_rd.push_back(WB + kk * COL + j);
            for (int j = 0; j < NIJ; j++) exp_rd.push_back(j);
            for (int j = 0; j < NIJ; j++) begin
`ifdef CTRL_SFP_ACC_EN
                exp_wa.push_back(j);
                exp_acc.push_back(kk > 0);
`else
                exp_wa.push_back(kk * NIJ + j);
                exp_acc.push_back(1'b0);
`endif
            end
        end
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prev_xcen = xmem_cen;
        start = 1'b1;
        ofifo_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        prev_ofv = ofifo_valid;
        busy_cyc = 0; nrd = 0; nwr = 0; finished = 1'b0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            chk({tag, "_l0wr_follows_read"}, inst[2], !prev_xcen);
            if (!xmem_cen) begin
                if (exp_rd.size() == 0) begin
                    chk({tag, "_extra_xmem_read"}, 1, 0);
                end else begin
                    chk($sformatf("%s_xaddr_%0d", tag, nrd), xmem_addr, exp_rd.pop_front());
                end
                nrd++;
            end
            if (!pmem_cen) begin
                chk({tag, "_wr_ctrl"}, {pmem_wen, inst[6], prev_ofv}, 3'b011);
                if (exp_wa.size() == 0) begin
                    chk({tag, "_extra_pmem_write"}, 1, 0);
                end else begin
                    chk($sformatf("%s_paddr_%0d", tag, nwr), pmem_addr, exp_wa.pop_front());
                    chk($sformatf("%s_acc_%0d", tag, nwr), inst[33], exp_acc.pop_front());
                end
                nwr++;
            end else begin
                chk({tag, "_no_ofifo_rd"}, {inst[33], inst[6], pmem_wen}, 3'b001);
            end
            if (done) finished = 1'b1;
            start = rnd && !finished && ($urandom_range(0, 19) == 0);
            ofifo_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_ofv = ofifo_valid;
            prev_xcen = xmem_cen;
        end
        chk({tag, "_done_seen"}, finished, 1);
        chk({tag, "_reads_left"}, exp_rd.size(), 0);
        chk({tag, "_writes_total"}, nwr, KIJ * NIJ);
        if (!rnd) chk({tag, "_busy_cycles"}, busy_cyc, KIJ * (2 * COL + ROW + COL + 3 * NIJ));
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("%s_after_done_%0d", tag, c), {busy, done, xmem_cen}, 3'b001);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        bit hit;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;

        // Reset, idle, first weight load, flush, activation load and execute.
        for (int c = 0; c < 3; c++)  vecs.push_back(mk(1, 0, 35'd0, 1, 0, 0));
        for (int c = 0; c < 10; c++) vecs.push_back(mk(0, 0, 35'd0, 1, 0, 0));
        for (int c = 0; c < COL; c++)
            vecs.push_back(mk(0, c == 0, (c >= 1) ? 35'd4 : 35'd0, 0, WB + c, 1));
        for (int c = 0; c < COL; c++)
            vecs.push_back(mk(0, 0, (c == 0) ? 35'd13 : 35'd9, 1, 0, 1));
        for (int c = 0; c < ROW + COL; c++) vecs.push_back(mk(0, 0, 35'd0, 1, 0, 1));
        for (int c = 0; c < NIJ; c++)
            vecs.push_back(mk(0, 0, (c >= 1) ? 35'd4 : 35'd0, 0, c, 1));
        for (int c = 0; c < NIJ; c++)
            vecs.push_back(mk(0, 0, (c == 0) ? 35'd14 : 35'd10, 1, 0, 1));

        foreach (vecs[n]) begin
            reset = vecs[n].rst; start = vecs[n].st; ofifo_valid = vecs[n].ofv;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_inst", n), inst, vecs[n].inst);
            chk($sformatf("v%0d_xcen", n), xmem_cen, vecs[n].xcen);
            chk($sformatf("v%0d_xaddr", n), xmem_addr, vecs[n].xaddr);
            chk($sformatf("v%0d_pcen_wen", n), {pmem_cen, pmem_wen}, {vecs[n].pcen, vecs[n].pcen});
            chk($sformatf("v%0d_paddr", n), pmem_addr, vecs[n].paddr);
            chk($sformatf("v%0d_busy_done", n), {busy, done}, {vecs[n].busy, vecs[n].done});
        end

        // Drain stall for k=0, then resume.
        ofifo_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall_%0d", c), {pmem_cen, inst[6], busy, xmem_cen, inst == 35'd0}, 5'b10111);
        end
        ofifo_valid = 1'b1;
        nw = 0; hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (!pmem_cen) begin
                chk($sformatf("drain_paddr_%0d", nw), pmem_addr, nw);
                nw++;
            end
            if (!xmem_cen) hit = 1'b1;
        end
        chk("drain_next_k_reached", hit, 1);
        chk("drain_write_count", nw, NIJ);
        chk("k1_first_xaddr", xmem_addr, WB + COL);

        // start ignored in A_EXEC, reset mid-run, rerun from k=0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (inst[1]) hit = 1'b1;
        end
        chk("reach_a_exec", hit, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored", {busy, xmem_cen, inst[1], inst[3]}, 4'b1111);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrun_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {busy, xmem_cen}, 2'b01);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rerun_first", {xmem_cen, busy}, 2'b01);
        chk("rerun_xaddr", xmem_addr, WB);

        run_full(1'b0);
        run_full(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
